// File: rtl/wb_stream_reader.sv
// Stream-to-memory DMA stage: buffers a valid/ready word stream in a FIFO and
// writes it to memory as Wishbone incrementing bursts, configured over a Wishbone slave.
module wb_stream_reader #(
  parameter int FIFO_AW       = 5,
  parameter int MAX_BURST_LEN = 32,
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WB_DW-1:0]   stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  input  logic [WB_AW-1:0]   wbs_adr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [WB_DW/8-1:0] wbs_sel_i,
  input  logic               wbs_we_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic [2:0]         wbs_cti_i,
  input  logic [1:0]         wbs_bte_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic               wbs_rty_o,
  output logic               irq_o
);
  localparam int CNT_W = WB_AW - 2;
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
  state_t state, state_d;

  logic [WB_AW-1:0] start_addr, adr_q;
  logic [WB_DW-1:0] buf_size, burst_size, rdata;
  logic             busy, irq, err;
  logic [CNT_W-1:0] total, blen, written, accepted, beats_left;
  logic [CNT_W-1:0] total_d, blen_d, remaining, wait_len;
  logic [2:0]       reg_sel;
  logic             acc, wr_en, csr_wr, start;
  logic             in_burst, last_beat, push, pop, bus_err;

  logic [WB_DW-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, fifo_count;
  logic             fifo_full;

  logic unused_inputs;
  assign unused_inputs = ^{wbm_dat_i, wbm_rty_i, wbs_sel_i, wbs_cti_i, wbs_bte_i,
                           wbs_adr_i[WB_AW-1:5], wbs_adr_i[1:0]};

  // Config slave: ack one cycle after request; writes commit on the edge that ends the ack cycle.
  assign reg_sel = wbs_adr_i[4:2];
  assign acc     = wbs_cyc_i & wbs_stb_i;
  assign wr_en   = acc & wbs_ack_o & wbs_we_i;
  assign csr_wr  = wr_en & (reg_sel == 3'd0);
  assign start   = csr_wr & wbs_dat_i[0] & ~busy;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = WB_DW'({err, irq, busy});
      3'd1:    rdata = WB_DW'(start_addr);
      3'd2:    rdata = buf_size;
      3'd3:    rdata = burst_size;
      3'd4:    rdata = WB_DW'(written);
      default: rdata = '0;
    endcase
  end

  always_comb begin
    total_d = CNT_W'(buf_size >> 2);
    if (burst_size == '0)                           blen_d = CNT_W'(1);
    else if (burst_size > WB_DW'(MAX_BURST_LEN))    blen_d = CNT_W'(MAX_BURST_LEN);
    else                                            blen_d = CNT_W'(burst_size);
    remaining = total - written;
    wait_len  = (remaining < blen) ? remaining : blen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      start_addr <= '0;
      buf_size   <= '0;
      burst_size <= '0;
    end else begin
      wbs_ack_o <= acc & ~wbs_ack_o;
      if (acc && !wbs_ack_o) wbs_dat_o <= rdata;
      if (wr_en && !busy) begin
        case (reg_sel)
          3'd1:    start_addr <= WB_AW'(wbs_dat_i);
          3'd2:    buf_size   <= wbs_dat_i;
          3'd3:    burst_size <= wbs_dat_i;
          default: ;
        endcase
      end
    end
  end

  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign irq_o     = irq;

  // Stream handshake: a word transfers on a rising edge where valid and ready are both high;
  // ready depends only on registered state, never on valid.
  assign stream_s_ready_o = busy & ~fifo_full & (accepted < total);
  assign push = stream_s_valid_i & stream_s_ready_o;

  assign in_burst  = (state == S_BURST);
  assign last_beat = (beats_left == CNT_W'(1));
  assign pop       = in_burst & wbm_ack_i & ~wbm_err_i;
  assign bus_err   = in_burst & wbm_err_i;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == (FIFO_AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= stream_s_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus_err) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      irq        <= 1'b0;
      err        <= 1'b0;
      total      <= '0;
      blen       <= '0;
      written    <= '0;
      accepted   <= '0;
      beats_left <= '0;
      adr_q      <= '0;
    end else begin
      if (push) accepted <= accepted + 1'b1;
      if (csr_wr && wbs_dat_i[1]) irq <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        err      <= 1'b0;
        total    <= total_d;
        blen     <= blen_d;
        adr_q    <= {start_addr[WB_AW-1:2], 2'b00};
        written  <= '0;
        accepted <= '0;
      end
      if (state == S_WAIT && state_d == S_BURST) beats_left <= wait_len;
      if (pop) begin
        adr_q      <= adr_q + WB_AW'(4);
        written    <= written + 1'b1;
        beats_left <= beats_left - 1'b1;
      end
      if (state == S_DONE) begin
        busy <= 1'b0;
        irq  <= 1'b1;
      end
      if (bus_err) begin
        busy <= 1'b0;
        irq  <= 1'b1;
        err  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (start) state_d = (total_d == '0) ? S_DONE : S_WAIT;
      S_WAIT:  if (CNT_W'(fifo_count) >= wait_len) state_d = S_BURST;
      S_BURST: begin
        if (wbm_err_i) state_d = S_IDLE;
        else if (wbm_ack_i && last_beat)
          state_d = (written + 1'b1 == total) ? S_DONE : S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Master outputs derive from the registered state so reset drops the bus asynchronously.
  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_we_o  = in_burst;
  assign wbm_sel_o = {(WB_DW/8){in_burst}};
  assign wbm_adr_o = in_burst ? adr_q : '0;
  assign wbm_dat_o = in_burst ? mem[rd_ptr[FIFO_AW-1:0]] : '0;
  assign wbm_cti_o = !in_burst ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
  assign wbm_bte_o = 2'b00;
endmodule

// File: tb/tb_wb_stream_reader.sv
// Directed-sequence bench for wb_stream_reader with random stream data, gaps and
// memory wait states, checked against a burst-partition reference model.
module tb_wb_stream_reader;
  localparam int MAXB = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stream_s_data_i = '0;
  logic        stream_s_valid_i = 1'b0;
  logic        stream_s_ready_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = '0;
  logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic [2:0]  wbs_cti_i = '0;
  logic [1:0]  wbs_bte_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o, irq_o;

  wb_stream_reader dut (
    .clk(clk), .rst_n(rst_n),
    .stream_s_data_i(stream_s_data_i), .stream_s_valid_i(stream_s_valid_i),
    .stream_s_ready_o(stream_s_ready_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .irq_o(irq_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int max_delay = 0, err_at = 0, beat_n = 0, wait_cnt = 0, gap_pct = 0, cyc_cycles = 0;
  bit stop_stream = 1'b0, chk_err_drop = 1'b0;
  logic [31:0] got_adr_q[$], got_dat_q[$], acc_q[$];
  logic [2:0]  got_cti_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: random wait states (with rty noise), optional err on a chosen beat
  initial begin
    forever begin
      @(negedge clk);
      if (chk_err_drop) begin
        chk_err_drop = 1'b0;
        check("err_cyc_drop", {wbm_cyc_o, wbm_stb_o}, 0);
      end
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0;
      if (rst_n && wbm_cyc_o && wbm_stb_o) begin
        cyc_cycles++;
        if (wait_cnt > 0) begin
          wait_cnt--;
          wbm_rty_i = 1'($urandom_range(0, 1));
        end else begin
          beat_n++;
          if (beat_n == err_at) begin
            wbm_err_i = 1'b1;
            chk_err_drop = 1'b1;
          end else begin
            wbm_ack_i = 1'b1;
            got_adr_q.push_back(wbm_adr_o);
            got_dat_q.push_back(wbm_dat_o);
            got_cti_q.push_back(wbm_cti_o);
            check("beat_ctrl", {wbm_sel_o, wbm_we_o, wbm_bte_o}, {4'hf, 1'b1, 2'b00});
          end
          wait_cnt = $urandom_range(0, max_delay);
        end
      end
    end
  end

  // Driver tasks
  task automatic wb_access(input logic [2:0] r, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    wbs_adr_i = {27'd0, r, 2'b00}; wbs_dat_i = wd; wbs_we_i = we;
    wbs_sel_i = 4'hf; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!wbs_ack_o && n < 20);
    check("wbs_ack_latency", n, 1);
    rd = wbs_dat_o;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_access(r, 1'b1, wd, dummy);
  endtask

  task automatic wb_read(input logic [2:0] r, output logic [31:0] rd);
    wb_access(r, 1'b0, 32'd0, rd);
  endtask

  task automatic drive_stream(input int n_offer);
    int sent;
    logic [31:0] w;
    sent = 0;
    w = $urandom();
    while (sent < n_offer && !stop_stream) begin
      @(negedge clk);
      stream_s_valid_i = ($urandom_range(0, 99) >= gap_pct);
      stream_s_data_i  = w;
      #1;
      if (stream_s_valid_i && stream_s_ready_o) begin
        @(posedge clk);
        acc_q.push_back(w);
        sent++;
        w = $urandom();
      end
    end
    @(negedge clk);
    stream_s_valid_i = 1'b0;
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n;
    n = 0;
    while (!irq_o && n < budget) begin @(posedge clk); #1; n++; end
    check({tag, "_irq"}, irq_o, 1);
  endtask

  task automatic start_run(input logic [31:0] sa, bsz, bst, input int dly, gap, errb);
    wb_write(3'd1, sa);
    wb_write(3'd2, bsz);
    wb_write(3'd3, bst);
    got_adr_q.delete(); got_dat_q.delete(); got_cti_q.delete(); acc_q.delete();
    beat_n = 0; err_at = errb; max_delay = dly; gap_pct = gap;
    stop_stream = 1'b0; cyc_cycles = 0;
    wb_write(3'd0, 32'd3);
    check("start_irq_clear", irq_o, 0);
    check("start_ready", stream_s_ready_o, ((bsz >> 2) != 0));
  endtask

  task automatic run_stream(input string tag, input int n_offer, input int budget);
    fork
      drive_stream(n_offer);
      begin
        wait_irq(tag, budget);
        repeat (2) @(posedge clk);
        stop_stream = 1'b1;
      end
    join
  endtask

  // Scoreboard: expected beats come from partitioning the buffer into clamp(BURST_SIZE) bursts
  task automatic check_beats(input string tag, input logic [31:0] sa, bsz, bst);
    int total, blen, pos, bstart, len;
    logic [31:0] exp_q[$];
    logic [31:0] ea;
    logic [2:0]  ec;
    total = int'(bsz >> 2);
    blen  = (bst == 0) ? 1 : (bst > MAXB) ? MAXB : int'(bst);
    foreach (acc_q[k]) exp_q.push_back(acc_q[k]);
    check({tag, "_accepted"}, exp_q.size(), total);
    check({tag, "_beats"}, got_adr_q.size(), total);
    for (int i = 0; i < total && i < got_adr_q.size(); i++) begin
      pos    = i % blen;
      bstart = i - pos;
      len    = (total - bstart < blen) ? total - bstart : blen;
      ea     = (sa & 32'hffff_fffc) + 32'(4 * i);
      ec     = (pos == len - 1) ? 3'b111 : 3'b010;
      check($sformatf("%s_adr%0d", tag, i), got_adr_q[i], ea);
      check($sformatf("%s_cti%0d", tag, i), got_cti_q[i], ec);
      if (i < exp_q.size()) check($sformatf("%s_dat%0d", tag, i), got_dat_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o}, 0);
    check("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 0);
    check("rst_slave", {wbs_ack_o, wbs_dat_o, stream_s_ready_o, irq_o}, 0);
    @(negedge clk); rst_n = 1'b1;
    wb_read(3'd0, rd); check("rst_csr", rd, 0);
    wb_read(3'd4, rd); check("rst_words_done", rd, 0);

    // Basic: two 4-beat bursts
    start_run(32'h40, 32'd32, 32'd4, 0, 0, 0);
    run_stream("basic", 8, 2000);
    check_beats("basic", 32'h40, 32'd32, 32'd4);
    wb_read(3'd4, rd); check("basic_words_done", rd, 8);
    wb_read(3'd0, rd); check("basic_csr", rd, 2);

    // Partial last burst: 4,4,2
    start_run(32'h40, 32'd40, 32'd4, 2, 25, 0);
    run_stream("partial", 10, 3000);
    check_beats("partial", 32'h40, 32'd40, 32'd4);

    // Backpressure with FIFO-sized bursts, one extra word offered, config writes while busy
    start_run(32'h1000, 32'd144, 32'd32, 5, 30, 0);
    fork
      drive_stream(37);
      begin
        wb_write(3'd1, 32'hdead_0000);
        wb_write(3'd3, 32'd7);
        wb_read(3'd1, rd); check("busy_start_addr_kept", rd, 32'h1000);
        wb_read(3'd3, rd); check("busy_burst_kept", rd, 32);
        wb_read(3'd0, rd); check("busy_csr", rd, 1);
        wait_irq("bp", 5000);
        repeat (4) @(posedge clk);
        stop_stream = 1'b1;
      end
    join
    check_beats("bp", 32'h1000, 32'd144, 32'd32);

    // Bus error on beat 2, then restart clears ERR
    start_run(32'h100, 32'd32, 32'd4, 0, 0, 2);
    run_stream("err", 8, 2000);
    wb_read(3'd0, rd); check("err_csr", rd, 6);
    check("err_irq_held", irq_o, 1);
    check("err_beats_before", got_adr_q.size(), 1);
    start_run(32'h200, 32'd16, 32'd4, 1, 10, 0);
    run_stream("after_err", 4, 2000);
    check_beats("after_err", 32'h200, 32'd16, 32'd4);
    wb_read(3'd0, rd); check("after_err_csr", rd, 2);

    // Zero-length buffer: irq one cycle later, no bus cycle
    start_run(32'h40, 32'd0, 32'd4, 0, 0, 0);
    @(posedge clk); #1;
    check("zero_irq_latency", irq_o, 1);
    repeat (3) @(posedge clk); #1;
    check("zero_no_cycle", cyc_cycles, 0);
    wb_read(3'd0, rd); check("zero_csr", rd, 2);

    // BURST_SIZE=0 behaves as single beats
    start_run(32'h300, 32'd12, 32'd0, 1, 20, 0);
    run_stream("blen0", 3, 2000);
    check_beats("blen0", 32'h300, 32'd12, 32'd0);

    // BURST_SIZE=100 clamps to 32
    start_run(32'h400, 32'd160, 32'd100, 0, 10, 0);
    run_stream("clamp", 40, 4000);
    check_beats("clamp", 32'h400, 32'd160, 32'd100);

    // Reset mid-burst during beat 3
    start_run(32'h40, 32'd32, 32'd8, 0, 0, 0);
    fork
      drive_stream(8);
      begin
        n = 0;
        while (got_adr_q.size() < 2 && n < 500) begin @(posedge clk); #1; n++; end
        check("rst_mid_pre_cyc", wbm_cyc_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o}, 0);
        check("rst_mid_adr_dat", {wbm_adr_o, wbm_dat_o}, 0);
        check("rst_mid_ready_irq", {stream_s_ready_o, irq_o}, 0);
        stop_stream = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read(3'd0, rd); check("rst_mid_csr", rd, 0);
    check("rst_mid_ready_idle", stream_s_ready_o, 0);
    start_run(32'h80, 32'd16, 32'd4, 0, 0, 0);
    run_stream("post_rst", 4, 2000);
    check_beats("post_rst", 32'h80, 32'd16, 32'd4);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
